read_edge_list: RTL

- Pipeline stage directly downstream of ReadSrcProperty in the graph-processing pipeline.
- Accepts one active vertex per transaction: vertex id, source property, edge-list base address and edge count.
- Walks that vertex's edge list in memory, one 64-bit edge word per read.
- Emits one output item per edge to the next stage (process-edge), carrying source property, destination id and edge weight.

---
 rtl/read_edge_list_if.sv | 47 ++++
 rtl/read_edge_list.sv | 120 ++++++++++++
 2 files changed

// File: rtl/read_edge_list_if.sv
// Port bundle for read_edge_list: upstream vertex item, edge-memory read port and downstream edge item.
// slave is the stage's view; master is the view of whatever drives it (upstream, memory and next stage).
interface read_edge_list_if #(
  parameter int ADDR_W = 32,
  parameter int VID_W  = 32,
  parameter int PROP_W = 32,
  parameter int CNT_W  = 16
);
  logic              i_valid;
  logic [VID_W-1:0]  i_vertex_id;
  logic [PROP_W-1:0] i_src_prop;
  logic [ADDR_W-1:0] i_edge_base;
  logic [CNT_W-1:0]  i_edge_count;
  logic              p_stall_can_accept;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              ready;
  logic              complete;
  logic [63:0]       edge_data;

  logic              o_valid;
  logic [VID_W-1:0]  o_vertex_id;
  logic [PROP_W-1:0] o_src_prop;
  logic [31:0]       o_dst_id;
  logic [31:0]       o_edge_data;
  logic              o_last;
  logic              n_stall_can_accept;

  modport slave (
    input  i_valid, i_vertex_id, i_src_prop, i_edge_base, i_edge_count,
    output p_stall_can_accept,
    output mem_req, mem_addr,
    input  ready, complete, edge_data,
    output o_valid, o_vertex_id, o_src_prop, o_dst_id, o_edge_data, o_last,
    input  n_stall_can_accept
  );

  modport master (
    output i_valid, i_vertex_id, i_src_prop, i_edge_base, i_edge_count,
    input  p_stall_can_accept,
    input  mem_req, mem_addr,
    output ready, complete, edge_data,
    input  o_valid, o_vertex_id, o_src_prop, o_dst_id, o_edge_data, o_last,
    output n_stall_can_accept
  );
endinterface

// File: rtl/read_edge_list.sv
// Walks one vertex's edge list (one 64-bit read per edge, one outstanding) and emits one item per edge; min 3 cycles/edge.
// Holds the memory request until ready and the output item while downstream stalls; READ_EDGE_LIST_PERF_EN adds perf counters.
module read_edge_list #(
  parameter int ADDR_W     = 32,
  parameter int VID_W      = 32,
  parameter int PROP_W     = 32,
  parameter int CNT_W      = 16,
  parameter int EDGE_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  read_edge_list_if.slave      bus
`ifdef READ_EDGE_LIST_PERF_EN
  ,
  output logic [31:0]          perf_edges,
  output logic [31:0]          perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr;
  logic [VID_W-1:0]  vid;
  logic [PROP_W-1:0] prop;
  logic [31:0]       dst;
  logic [31:0]       wgt;
  logic              last;
  logic              can_accept;
  logic              accept;
  logic              handoff;
  logic              is_last;

  // can_accept is a register so it stays low through reset and rises on the first clock after release.
  assign accept  = (state == IDLE) && can_accept && bus.i_valid;
  assign handoff = (state == EMIT) && bus.n_stall_can_accept;
  assign is_last = (idx == count - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.mem_req = 1'b0;
    bus.o_valid = 1'b0;
    unique case (state)
      IDLE: if (accept && bus.i_edge_count != '0) state_nxt = REQ;
      REQ: begin
        bus.mem_req = 1'b1;
        if (bus.ready) state_nxt = WAIT;
      end
      WAIT: if (bus.complete) state_nxt = EMIT;
      EMIT: begin
        bus.o_valid = 1'b1;
        if (bus.n_stall_can_accept) state_nxt = last ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      can_accept <= 1'b0;
      idx        <= '0;
      count      <= '0;
      addr       <= '0;
      vid        <= '0;
      prop       <= '0;
      dst        <= '0;
      wgt        <= '0;
      last       <= 1'b0;
    end else begin
      can_accept <= (state_nxt == IDLE);
      if (accept) begin
        vid   <= bus.i_vertex_id;
        prop  <= bus.i_src_prop;
        addr  <= bus.i_edge_base;
        count <= bus.i_edge_count;
        idx   <= '0;
      end
      if (state == WAIT && bus.complete) begin
        dst  <= bus.edge_data[31:0];
        wgt  <= bus.edge_data[63:32];
        last <= is_last;
      end
      // Running address equals base + idx*EDGE_BYTES and wraps naturally at 2^ADDR_W.
      if (handoff && !last) begin
        idx  <= idx + CNT_W'(1);
        addr <= addr + ADDR_W'(EDGE_BYTES);
      end
    end
  end

  assign bus.p_stall_can_accept = can_accept;
  assign bus.mem_addr           = addr;
  assign bus.o_vertex_id        = vid;
  assign bus.o_src_prop         = prop;
  assign bus.o_dst_id           = dst;
  assign bus.o_edge_data        = wgt;
  assign bus.o_last             = last;

`ifdef READ_EDGE_LIST_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_edges        <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (handoff) perf_edges <= perf_edges + 32'd1;
      if ((state == REQ && !bus.ready) || (state == EMIT && !bus.n_stall_can_accept))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
